dm_operand_stage: RTL and testbench
===================================

# dm_operand_stage

Parametrised decode/operand-fetch stage that replaces the fixed two-source bypass stage. It holds the architectural register file and resolves both source operands against NUM_BYPASS prioritised bypass sources plus the same-cycle write-back. It raises a real stall on not-yet-available producer data, such as a load in flight. Results are registered into an output pipeline register with a valid/ready handshake, between the decoder and the ALU stage.

## Interface
- REG_ADDRESS_SIZE, 5, register index width; the file has 2**REG_ADDRESS_SIZE entries.
- REG_SIZE, 32, data width.
- STATIC_SIZE, 40, width of the pass-through decoded control bundle.
- NUM_BYPASS, 3, number of bypass sources; index 0 is the youngest and has the highest priority.
- CNT_SIZE, 16, stall counter width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_addr_r1, in_addr_r2  in  REG_ADDRESS_SIZE each  source register indices.
- in_use_r1, in_use_r2  in  1 each  the source is actually read.
- in_Ie  in  1  operand2 is the immediate.
- in_immediate  in  REG_SIZE  immediate value.
- in_static  in  STATIC_SIZE  control bundle, passed through unchanged.
- byp_d  in  NUM_BYPASS*(REG_ADDRESS_SIZE+1)  per source {addr, valid}; bit 0 of each slice is valid; slice i sits at [i*(REG_ADDRESS_SIZE+1) +: REG_ADDRESS_SIZE+1].
- byp_ready  in  NUM_BYPASS  the source's data is available this cycle.
- byp_value  in  NUM_BYPASS*REG_SIZE  bypass data; slice i sits at [i*REG_SIZE +: REG_SIZE].
- wb_addr  in  REG_ADDRESS_SIZE  write-back index.
- wb_value  in  REG_SIZE  write-back data.
- wb_we  in  1  write-back enable.
- flush  in  1  synchronous kill of the output register.
- out_valid  out  1  output register holds an instruction.
- out_ready  in  1  the downstream stage consumes the output.
- out_operand1, out_operand2  out  REG_SIZE each  resolved operands.
- out_static  out  STATIC_SIZE  registered in_static.
- stall_count  out  CNT_SIZE  saturating count of stall cycles.

## Operation
Operand resolution is combinational and applies to each source s with index a, in priority order:
- If a==0, the result is 0. Register 0 is hardwired to 0 and never matches a bypass source or write-back.
- Otherwise take the lowest i with byp_d slice valid and addr==a:
  - if byp_ready[i]=1, the result is byp_value slice i;
  - if byp_ready[i]=0, a hazard is raised. Older sources are not consulted.
- Otherwise, if wb_we=1 and wb_addr==a, the result is wb_value (write-through).
- Otherwise the result is the register file content.

Operand rules:
- operand2 = in_immediate when in_Ie=1. Source 2 is then not resolved and cannot cause a hazard.
- hazard = in_valid & ((in_use_r1 & hz1) | (in_use_r2 & ~in_Ie & hz2)). An unused source never stalls.

Handshake:
- in_ready = ~hazard & ~flush & (~out_valid | out_ready).
- Accept = in_valid & in_ready.
- On accept, out_operand1/2 and out_static load and out_valid=1.
- Otherwise, if out_ready=1 or flush=1, out_valid=0 (bubble). Data registers hold their values.
- With out_valid=1 and out_ready=0, all output registers hold.

Register file and stall counter:
- Register file write at the clock edge when wb_we=1 and wb_addr!=0. Writes to index 0 are ignored.
- stall_count increments by 1 each cycle with in_valid=1 and in_ready=0, and saturates at all-ones.

## Timing
- Latency is 1 cycle from accept to out_valid.
- Throughput is 1 instruction per cycle while out_ready=1 and there is no hazard.
- Reset asserted (reset=0), asynchronously:
  - out_valid=0;
  - out_operand1, out_operand2 and out_static = 0;
  - all register file entries = 0;
  - stall_count=0.
- A reset asserted mid-stall discards the pending instruction. The upstream stage must re-present it.
- Simultaneous flush and in_valid: the instruction is not accepted and out_valid=0 the next cycle.
- A write-back and a read of the same index in the same cycle return wb_value. The file is updated at that edge.
- A hazard source becoming ready releases the stall in the same cycle: in_ready rises combinationally.
- in_ready depends combinationally on out_ready, byp_*, flush and the in_* fields. There is no combinational path from in_valid to out_valid.

## Test plan
- Reset, then write r5=0x1234 via wb. Next cycle issue r1=5, r2=0, in_Ie=0 -> out_operand1=0x1234 and out_operand2=0 one cycle after accept.
- r1=7 with byp slice0={7,1}, byp_value0=0xA and slice2={7,1}, byp_value2=0xC, both ready -> operand1=0xA (priority to index 0).
- r2=9, in_use_r2=1, slice1={9,1}, byp_ready[1]=0 for 3 cycles, then 1 with value 0x55 -> in_ready=0 for 3 cycles, stall_count=3, then accept with operand2=0x55.
- Same hazard on r2 but in_Ie=1 and immediate 0x80 -> no stall and operand2=0x80.
- out_ready=0 with out_valid=1 and a new in_valid -> in_ready=0 and outputs hold. Raise out_ready -> accept next edge.
- Assert flush with in_valid=1 and out_valid=1 -> next cycle out_valid=0 and the instruction is not accepted. Asynchronous reset during a stall -> outputs and stall_count clear immediately.

Source files
------------

// File: rtl/dm_operand_stage.sv
// Decode/operand-fetch stage: register file, prioritised bypass resolution with
// hazard stall, and a valid/ready output pipeline register.
module dm_operand_stage #(
  parameter int REG_ADDRESS_SIZE = 5,
  parameter int REG_SIZE         = 32,
  parameter int STATIC_SIZE      = 40,
  parameter int NUM_BYPASS       = 3,
  parameter int CNT_SIZE         = 16
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic [REG_ADDRESS_SIZE-1:0]                in_addr_r1,
  input  logic [REG_ADDRESS_SIZE-1:0]                in_addr_r2,
  input  logic                                       in_use_r1,
  input  logic                                       in_use_r2,
  input  logic                                       in_Ie,
  input  logic [REG_SIZE-1:0]                        in_immediate,
  input  logic [STATIC_SIZE-1:0]                     in_static,
  input  logic [NUM_BYPASS*(REG_ADDRESS_SIZE+1)-1:0] byp_d,
  input  logic [NUM_BYPASS-1:0]                      byp_ready,
  input  logic [NUM_BYPASS*REG_SIZE-1:0]             byp_value,
  input  logic [REG_ADDRESS_SIZE-1:0]                wb_addr,
  input  logic [REG_SIZE-1:0]                        wb_value,
  input  logic                                       wb_we,
  input  logic                                       flush,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [REG_SIZE-1:0]                        out_operand1,
  output logic [REG_SIZE-1:0]                        out_operand2,
  output logic [STATIC_SIZE-1:0]                     out_static,
  output logic [CNT_SIZE-1:0]                        stall_count
);

  localparam int BW    = REG_ADDRESS_SIZE + 1;
  localparam int NREGS = 2 ** REG_ADDRESS_SIZE;

  logic [REG_SIZE-1:0] rf [NREGS];
  logic [REG_SIZE-1:0] rf_rd1, rf_rd2;
  logic [REG_SIZE-1:0] res1, res2, op2_next;
  logic                hz1, hz2, hazard, accept;

  assign rf_rd1 = rf[in_addr_r1];
  assign rf_rd2 = rf[in_addr_r2];

  // Returns {hazard, value}. Walking oldest-to-youngest lets the youngest match win;
  // a not-ready youngest match masks every older source and the write-back.
  function automatic logic [REG_SIZE:0] resolve(
    input logic [REG_ADDRESS_SIZE-1:0]    a,
    input logic [REG_SIZE-1:0]            rf_data,
    input logic [NUM_BYPASS*BW-1:0]       bd,
    input logic [NUM_BYPASS-1:0]          br,
    input logic [NUM_BYPASS*REG_SIZE-1:0] bv,
    input logic                           we,
    input logic [REG_ADDRESS_SIZE-1:0]    wa,
    input logic [REG_SIZE-1:0]            wv
  );
    logic [REG_SIZE:0] r;
    r = (we && wa == a) ? {1'b0, wv} : {1'b0, rf_data};
    for (int i = NUM_BYPASS - 1; i >= 0; i--) begin
      if (bd[i*BW] && bd[i*BW+1 +: REG_ADDRESS_SIZE] == a)
        r = {~br[i], bv[i*REG_SIZE +: REG_SIZE]};
    end
    if (a == '0) r = '0;
    return r;
  endfunction

  assign {hz1, res1} = resolve(in_addr_r1, rf_rd1, byp_d, byp_ready, byp_value,
                               wb_we, wb_addr, wb_value);
  assign {hz2, res2} = resolve(in_addr_r2, rf_rd2, byp_d, byp_ready, byp_value,
                               wb_we, wb_addr, wb_value);

  assign op2_next = in_Ie ? in_immediate : res2;
  assign hazard   = in_valid & ((in_use_r1 & hz1) | (in_use_r2 & ~in_Ie & hz2));
  assign in_ready = ~hazard & ~flush & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid    <= 1'b0;
      out_operand1 <= '0;
      out_operand2 <= '0;
      out_static   <= '0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      out_operand1 <= res1;
      out_operand2 <= op2_next;
      out_static   <= in_static;
    end else if (out_ready || flush) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (wb_we && wb_addr != '0) begin
      rf[wb_addr] <= wb_value;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
    end else if (in_valid && !in_ready && stall_count != {CNT_SIZE{1'b1}}) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_dm_operand_stage.sv
// Self-checking bench for dm_operand_stage: a per-cycle reference model plus
// directed scenarios with literal expectations.
module tb_dm_operand_stage;

  localparam int RA  = 5;
  localparam int RS  = 32;
  localparam int SS  = 40;
  localparam int NB  = 3;
  localparam int CNT = 4;
  localparam int BW  = RA + 1;

  logic               clk, reset;
  logic               in_valid, in_ready;
  logic [RA-1:0]      in_addr_r1, in_addr_r2;
  logic               in_use_r1, in_use_r2, in_Ie;
  logic [RS-1:0]      in_immediate;
  logic [SS-1:0]      in_static;
  logic [NB*BW-1:0]   byp_d;
  logic [NB-1:0]      byp_ready;
  logic [NB*RS-1:0]   byp_value;
  logic [RA-1:0]      wb_addr;
  logic [RS-1:0]      wb_value;
  logic               wb_we, flush;
  logic               out_valid, out_ready;
  logic [RS-1:0]      out_operand1, out_operand2;
  logic [SS-1:0]      out_static;
  logic [CNT-1:0]     stall_count;

  int n_checks = 0;
  int n_fail   = 0;
  bit compare_en = 0;

  dm_operand_stage #(
    .REG_ADDRESS_SIZE(RA), .REG_SIZE(RS), .STATIC_SIZE(SS),
    .NUM_BYPASS(NB), .CNT_SIZE(CNT)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_addr_r1(in_addr_r1), .in_addr_r2(in_addr_r2),
    .in_use_r1(in_use_r1), .in_use_r2(in_use_r2), .in_Ie(in_Ie),
    .in_immediate(in_immediate), .in_static(in_static),
    .byp_d(byp_d), .byp_ready(byp_ready), .byp_value(byp_value),
    .wb_addr(wb_addr), .wb_value(wb_value), .wb_we(wb_we),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_operand1(out_operand1), .out_operand2(out_operand2),
    .out_static(out_static), .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [RS-1:0] m_rf [32];
  bit            m_ov;
  logic [RS-1:0] m_op1, m_op2;
  logic [SS-1:0] m_st;
  int            m_cnt;

  function automatic void m_resolve(input logic [RA-1:0] a, output logic [RS-1:0] v,
                                    output bit hz);
    hz = 0;
    v  = '0;
    if (a == 0) return;
    for (int i = 0; i < NB; i++) begin
      if (byp_d[i*BW] == 1'b1 && byp_d[i*BW+1 +: RA] == a) begin
        hz = !byp_ready[i];
        v  = byp_value[i*RS +: RS];
        return;
      end
    end
    if (wb_we && wb_addr == a) begin
      v = wb_value;
      return;
    end
    v = m_rf[a];
  endfunction

  function automatic bit m_in_ready();
    logic [RS-1:0] v1, v2;
    bit h1, h2, haz;
    m_resolve(in_addr_r1, v1, h1);
    m_resolve(in_addr_r2, v2, h2);
    haz = in_valid && ((in_use_r1 && h1) || (in_use_r2 && !in_Ie && h2));
    return !haz && !flush && (!m_ov || out_ready);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) m_rf[i] = '0;
      m_ov = 0; m_op1 = '0; m_op2 = '0; m_st = '0; m_cnt = 0;
    end else begin
      logic [RS-1:0] v1, v2;
      bit h1, h2, rdy;
      m_resolve(in_addr_r1, v1, h1);
      m_resolve(in_addr_r2, v2, h2);
      rdy = m_in_ready();
      if (in_valid && !rdy && m_cnt < (1 << CNT) - 1) m_cnt++;
      if (in_valid && rdy) begin
        m_ov = 1; m_op1 = v1; m_op2 = in_Ie ? in_immediate : v2; m_st = in_static;
      end else if (out_ready || flush) begin
        m_ov = 0;
      end
      if (wb_we && wb_addr != 0) m_rf[wb_addr] = wb_value;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, half a cycle away from the active edge
  always @(negedge clk) begin
    if (compare_en) begin
      checkOutput("cyc_in_ready", 64'(in_ready), 64'(m_in_ready()));
      checkOutput("cyc_out_valid", 64'(out_valid), 64'(m_ov));
      checkOutput("cyc_stall_count", 64'(stall_count), 64'(m_cnt));
      if (m_ov) begin
        checkOutput("cyc_operand1", 64'(out_operand1), 64'(m_op1));
        checkOutput("cyc_operand2", 64'(out_operand2), 64'(m_op2));
        checkOutput("cyc_static", 64'(out_static), 64'(m_st));
      end
    end
  end

  task automatic applyStimulus(input bit v, input logic [RA-1:0] r1, input logic [RA-1:0] r2,
                               input bit u1, input bit u2, input bit ie,
                               input logic [RS-1:0] imm, input logic [SS-1:0] st);
    in_valid = v; in_addr_r1 = r1; in_addr_r2 = r2;
    in_use_r1 = u1; in_use_r2 = u2; in_Ie = ie;
    in_immediate = imm; in_static = st;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearByp();
    byp_d = '0; byp_ready = '0; byp_value = '0;
  endtask

  initial begin
    #100000;
    n_fail++;
    $display("[TB] FAIL watchdog timeout");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    reset = 1'b0; out_ready = 1'b1; flush = 1'b0;
    wb_we = 1'b0; wb_addr = '0; wb_value = '0;
    clearByp();
    applyStimulus(0, 0, 0, 0, 0, 0, '0, '0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    compare_en = 1;
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_stall_count", 64'(stall_count), 64'd0);
    checkOutput("reset_operand1", 64'(out_operand1), 64'd0);

    // Register file write then read
    wb_we = 1; wb_addr = 5; wb_value = 32'h1234;
    tick();
    wb_we = 0;
    applyStimulus(1, 5, 0, 1, 1, 0, '0, 40'hA5_0000_0001);
    tick();
    checkOutput("rf_read_valid", 64'(out_valid), 64'd1);
    checkOutput("rf_read_op1", 64'(out_operand1), 64'h1234);
    checkOutput("rf_read_op2_r0", 64'(out_operand2), 64'd0);
    checkOutput("rf_read_static", 64'(out_static), 64'hA5_0000_0001);

    // Bypass priority: youngest source wins
    byp_d[0*BW +: BW] = {5'd7, 1'b1}; byp_value[0*RS +: RS] = 32'hA;
    byp_d[2*BW +: BW] = {5'd7, 1'b1}; byp_value[2*RS +: RS] = 32'hC;
    byp_ready = 3'b111;
    applyStimulus(1, 7, 0, 1, 0, 0, '0, 40'h00_0000_0002);
    tick();
    checkOutput("byp_priority_op1", 64'(out_operand1), 64'hA);

    // Hazard on r2 for three cycles, then released
    clearByp();
    byp_d[1*BW +: BW] = {5'd9, 1'b1};
    applyStimulus(1, 0, 9, 0, 1, 0, '0, 40'h00_0000_0003);
    #1 checkOutput("hazard_in_ready", 64'(in_ready), 64'd0);
    tick(); tick(); tick();
    byp_ready[1] = 1'b1; byp_value[1*RS +: RS] = 32'h55;
    #1;
    checkOutput("hazard_release_ready", 64'(in_ready), 64'd1);
    checkOutput("hazard_stall_count", 64'(stall_count), 64'd3);
    tick();
    checkOutput("hazard_op2", 64'(out_operand2), 64'h55);

    // Same hazard masked by immediate
    byp_ready = '0;
    applyStimulus(1, 0, 9, 0, 1, 1, 32'h80, 40'h00_0000_0004);
    #1 checkOutput("imm_no_stall", 64'(in_ready), 64'd1);
    tick();
    checkOutput("imm_op2", 64'(out_operand2), 64'h80);
    checkOutput("imm_stall_count", 64'(stall_count), 64'd3);

    // Downstream back-pressure holds outputs
    clearByp();
    out_ready = 0;
    applyStimulus(1, 5, 0, 1, 0, 0, '0, 40'h00_0000_0005);
    #1 checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
    tick(); tick();
    checkOutput("bp_hold_op2", 64'(out_operand2), 64'h80);
    checkOutput("bp_hold_valid", 64'(out_valid), 64'd1);
    out_ready = 1;
    #1 checkOutput("bp_release_ready", 64'(in_ready), 64'd1);
    tick();
    checkOutput("bp_accept_op1", 64'(out_operand1), 64'h1234);
    checkOutput("bp_accept_static", 64'(out_static), 64'h00_0000_0005);

    // Flush kills output and blocks acceptance
    flush = 1;
    applyStimulus(1, 5, 0, 1, 0, 0, '0, 40'h00_0000_0006);
    tick();
    checkOutput("flush_out_valid", 64'(out_valid), 64'd0);
    checkOutput("flush_stall_count", 64'(stall_count), 64'd6);
    flush = 0;
    applyStimulus(0, 0, 0, 0, 0, 0, '0, '0);
    tick();

    // Write-through, r0 write ignored, bypass beats write-back, unused hazard
    wb_we = 1; wb_addr = 3; wb_value = 32'hDEAD;
    applyStimulus(1, 3, 0, 1, 1, 0, '0, 40'h00_0000_0007);
    tick();
    checkOutput("wt_op1", 64'(out_operand1), 64'hDEAD);
    wb_addr = 0; wb_value = 32'hFFFF_FFFF;
    applyStimulus(1, 0, 3, 1, 1, 0, '0, 40'h00_0000_0008);
    tick();
    checkOutput("r0_op1", 64'(out_operand1), 64'd0);
    checkOutput("rf_r3_op2", 64'(out_operand2), 64'hDEAD);
    wb_addr = 3; wb_value = 32'h1111;
    byp_d[2*BW +: BW] = {5'd3, 1'b1}; byp_ready[2] = 1'b1; byp_value[2*RS +: RS] = 32'h77;
    applyStimulus(1, 3, 3, 1, 1, 0, '0, 40'h00_0000_0009);
    tick();
    checkOutput("byp_over_wb_op1", 64'(out_operand1), 64'h77);
    checkOutput("byp_over_wb_op2", 64'(out_operand2), 64'h77);
    wb_we = 0;
    clearByp();
    byp_d[0*BW +: BW] = {5'd4, 1'b1};
    applyStimulus(1, 4, 6, 0, 1, 0, '0, 40'h00_0000_000A);
    #1 checkOutput("unused_hz_ready", 64'(in_ready), 64'd1);
    tick();
    checkOutput("unused_hz_op2", 64'(out_operand2), 64'd0);

    // Long stall saturates the counter, then asynchronous reset mid-stall
    clearByp();
    out_ready = 0;
    byp_d[1*BW +: BW] = {5'd9, 1'b1};
    applyStimulus(1, 9, 0, 1, 0, 0, '0, 40'h00_0000_000B);
    repeat (20) tick();
    checkOutput("sat_stall_count", 64'(stall_count), 64'hF);
    #2 reset = 0;
    #1;
    checkOutput("areset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("areset_stall_count", 64'(stall_count), 64'd0);
    checkOutput("areset_operand1", 64'(out_operand1), 64'd0);
    checkOutput("areset_static", 64'(out_static), 64'd0);
    clearByp();
    out_ready = 1;
    applyStimulus(0, 0, 0, 0, 0, 0, '0, '0);
    tick();
    reset = 1;
    applyStimulus(1, 5, 3, 1, 1, 0, '0, 40'h00_0000_000C);
    tick();
    checkOutput("post_reset_r5", 64'(out_operand1), 64'd0);
    checkOutput("post_reset_r3", 64'(out_operand2), 64'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, '0, '0);
    tick();
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
